// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tlc_pkg
//  Purpose  : Shared state encoding, lamp-vector constants and helpers for the
//             multi-phase traffic light controller.
//  Revision : 1.0 - initial release
// ============================================================================
package tlc_pkg;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_FLASH   = 2'd3
    } tlc_state_e;

    localparam int         c_max_dir   = 8;
    localparam logic [7:0] c_lamps_on  = 8'hFF;
    localparam logic [7:0] c_lamps_off = 8'h00;
    localparam logic [7:0] c_lamp_dir0 = 8'h01;

    function automatic int tlc_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_rr_select.sv
`default_nettype none
// ============================================================================
//  Module   : tlc_rr_select
//  Purpose  : Combinational round-robin picker: first demanding direction
//             after the current phase, wrapping back onto the current phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tlc_rr_select #(
    parameter int NUM_DIR = 4
) (
    input  logic [NUM_DIR-1:0]         sensor,
    input  logic [$clog2(NUM_DIR)-1:0] phase,
    output logic [$clog2(NUM_DIR)-1:0] next_phase
);

    localparam int c_pw = $clog2(NUM_DIR);

    logic            w_found;
    logic [c_pw-1:0] w_idx;

    always_comb begin
        // With no demand anywhere the controller simply steps to the neighbour.
        next_phase = c_pw'((int'(phase) + 1) % NUM_DIR);
        w_found    = 1'b0;
        w_idx      = '0;
        for (int i = 1; i <= NUM_DIR; i++) begin
            w_idx = c_pw'((int'(phase) + i) % NUM_DIR);
            if (!w_found && sensor[w_idx]) begin
                next_phase = w_idx;
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_phase_traffic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multi_phase_traffic_ctrl
//  Purpose  : Demand-actuated N-phase intersection controller with min/max
//             green, yellow, all-red clearance and night flashing mode.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_phase_traffic_ctrl
    import tlc_pkg::*;
#(
    parameter int NUM_DIR   = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int FLASH_T   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_DIR-1:0]         sensor,
    input  logic                       night_mode,
    output logic [NUM_DIR-1:0]         red,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [NUM_DIR-1:0]         green,
    output logic [$clog2(NUM_DIR)-1:0] phase
);

    localparam int c_pw   = $clog2(NUM_DIR);
    localparam int c_tmax = tlc_max4(GREEN_MAX, YELLOW_T, ALLRED_T, FLASH_T);
    localparam int c_tw   = $clog2(c_tmax) + 1;

    localparam logic [c_tw-1:0] c_green_min_last = c_tw'(GREEN_MIN - 1);
    localparam logic [c_tw-1:0] c_green_max_last = c_tw'(GREEN_MAX - 1);
    localparam logic [c_tw-1:0] c_green_sat      = c_tw'(GREEN_MAX);
    localparam logic [c_tw-1:0] c_yellow_last    = c_tw'(YELLOW_T - 1);
    localparam logic [c_tw-1:0] c_allred_last    = c_tw'(ALLRED_T - 1);
    localparam logic [c_tw-1:0] c_flash_last     = c_tw'(FLASH_T - 1);
    localparam logic [c_pw-1:0] c_last_dir       = c_pw'(NUM_DIR - 1);

    localparam logic [NUM_DIR-1:0] c_all  = c_lamps_on[NUM_DIR-1:0];
    localparam logic [NUM_DIR-1:0] c_none = c_lamps_off[NUM_DIR-1:0];
    localparam logic [NUM_DIR-1:0] c_dir0 = c_lamp_dir0[NUM_DIR-1:0];

    if (NUM_DIR < 2 || NUM_DIR > c_max_dir || GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN ||
        YELLOW_T < 1 || ALLRED_T < 1 || FLASH_T < 1) begin : g_param_check
        $fatal(1, "multi_phase_traffic_ctrl: illegal parameter value");
    end

    tlc_state_e         r_state;
    tlc_state_e         w_state_nxt;
    logic [c_tw-1:0]    r_timer;
    logic [c_tw-1:0]    w_timer_nxt;
    logic [c_pw-1:0]    r_phase;
    logic [c_pw-1:0]    w_phase_nxt;
    logic [c_pw-1:0]    w_rr_phase;
    logic               r_flash;
    logic               w_flash_nxt;
    logic [NUM_DIR-1:0] r_red;
    logic [NUM_DIR-1:0] r_yellow;
    logic [NUM_DIR-1:0] r_green;
    logic [NUM_DIR-1:0] w_red_nxt;
    logic [NUM_DIR-1:0] w_yellow_nxt;
    logic [NUM_DIR-1:0] w_green_nxt;
    logic [NUM_DIR-1:0] w_cur_mask;
    logic [NUM_DIR-1:0] w_nxt_mask;
    logic               w_competing;
    logic               w_own_demand;

    tlc_rr_select #(
        .NUM_DIR    (NUM_DIR)
    ) u_rr_select (
        .sensor     (sensor),
        .phase      (r_phase),
        .next_phase (w_rr_phase)
    );

    assign w_cur_mask   = c_dir0 << r_phase;
    assign w_own_demand = |(sensor & w_cur_mask);
    assign w_competing  = (|(sensor & ~w_cur_mask)) | night_mode;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_phase_nxt = r_phase;
        w_flash_nxt = r_flash;
        case (r_state)
            ST_ALL_RED: begin
                if (r_timer >= c_allred_last) begin
                    w_timer_nxt = '0;
                    if (night_mode) begin
                        w_state_nxt = ST_FLASH;
                        w_flash_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_GREEN;
                        w_phase_nxt = w_rr_phase;
                    end
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_GREEN: begin
                if (w_competing && ((r_timer >= c_green_max_last) ||
                                    ((r_timer >= c_green_min_last) && !w_own_demand))) begin
                    w_state_nxt = ST_YELLOW;
                    w_timer_nxt = '0;
                end else if (r_timer < c_green_sat) begin
                    // Saturate so an indefinitely resting green never wraps.
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_YELLOW: begin
                if (r_timer >= c_yellow_last) begin
                    w_state_nxt = ST_ALL_RED;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_FLASH: begin
                if (!night_mode) begin
                    // Parking the phase on the last direction restarts service at 0.
                    w_state_nxt = ST_ALL_RED;
                    w_timer_nxt = '0;
                    w_phase_nxt = c_last_dir;
                    w_flash_nxt = 1'b0;
                end else if (r_timer >= c_flash_last) begin
                    w_timer_nxt = '0;
                    w_flash_nxt = ~r_flash;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_ALL_RED;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Lamps are decoded from the next state so they change on the same edge.
    always_comb begin
        w_red_nxt    = c_all;
        w_yellow_nxt = c_none;
        w_green_nxt  = c_none;
        w_nxt_mask   = c_dir0 << w_phase_nxt;
        case (w_state_nxt)
            ST_GREEN: begin
                w_green_nxt = w_nxt_mask;
                w_red_nxt   = ~w_nxt_mask;
            end
            ST_YELLOW: begin
                w_yellow_nxt = w_nxt_mask;
                w_red_nxt    = ~w_nxt_mask;
            end
            ST_FLASH: begin
                w_yellow_nxt = {NUM_DIR{w_flash_nxt}} & c_dir0;
                w_red_nxt    = {NUM_DIR{w_flash_nxt}} & ~c_dir0;
            end
            default: begin
                w_red_nxt = c_all;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_ALL_RED;
            r_timer  <= '0;
            r_phase  <= c_last_dir;
            r_flash  <= 1'b0;
            r_red    <= c_all;
            r_yellow <= c_none;
            r_green  <= c_none;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_phase  <= w_phase_nxt;
            r_flash  <= w_flash_nxt;
            r_red    <= w_red_nxt;
            r_yellow <= w_yellow_nxt;
            r_green  <= w_green_nxt;
        end
    end

    assign red    = r_red;
    assign yellow = r_yellow;
    assign green  = r_green;
    assign phase  = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_multi_phase_traffic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_phase_traffic_ctrl
//  Purpose  : Directed plus randomized bench for multi_phase_traffic_ctrl
//             against a cycle-count reference model of the signal rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_phase_traffic_ctrl;

    localparam int N    = 4;
    localparam int GMIN = 4;
    localparam int GMAX = 10;
    localparam int YT   = 2;
    localparam int AT   = 1;
    localparam int FT   = 3;

    localparam int M_AR = 0;
    localparam int M_GR = 1;
    localparam int M_YE = 2;
    localparam int M_FL = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] sensor = '0;
    logic         night_mode = 1'b0;
    logic [N-1:0] red;
    logic [N-1:0] yellow;
    logic [N-1:0] green;
    logic [1:0]   phase;

    int checks = 0;
    int errors = 0;

    // Reference model: mode, remaining cycles of fixed intervals, green age.
    int m_mode;
    int m_left;
    int m_age;
    int m_phase;
    int m_fcnt;
    bit m_flash;

    multi_phase_traffic_ctrl #(
        .NUM_DIR    (N),
        .GREEN_MIN  (GMIN),
        .GREEN_MAX  (GMAX),
        .YELLOW_T   (YT),
        .ALLRED_T   (AT),
        .FLASH_T    (FT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sensor     (sensor),
        .night_mode (night_mode),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] s, input int ph);
        for (int k = 1; k <= N; k++) begin
            if (s[(ph + k) % N]) return (ph + k) % N;
        end
        return (ph + 1) % N;
    endfunction

    task automatic model_reset();
        m_mode  = M_AR;
        m_left  = AT;
        m_age   = 0;
        m_phase = N - 1;
        m_fcnt  = FT;
        m_flash = 1'b0;
    endtask

    task automatic model_step();
        logic [N-1:0] others;
        bit           compete;
        case (m_mode)
            M_AR: begin
                m_left--;
                if (m_left == 0) begin
                    if (night_mode) begin
                        m_mode  = M_FL;
                        m_flash = 1'b1;
                        m_fcnt  = FT;
                    end else begin
                        m_mode  = M_GR;
                        m_phase = pick(sensor, m_phase);
                        m_age   = 0;
                    end
                end
            end
            M_GR: begin
                m_age++;
                others  = sensor & ~(N'(1) << m_phase);
                compete = (others != '0) || night_mode;
                if (compete && ((m_age >= GMIN && !sensor[m_phase]) || m_age >= GMAX)) begin
                    m_mode = M_YE;
                    m_left = YT;
                end
            end
            M_YE: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = M_AR;
                    m_left = AT;
                end
            end
            default: begin
                if (!night_mode) begin
                    m_mode  = M_AR;
                    m_left  = AT;
                    m_phase = N - 1;
                    m_flash = 1'b0;
                end else begin
                    m_fcnt--;
                    if (m_fcnt == 0) begin
                        m_flash = !m_flash;
                        m_fcnt  = FT;
                    end
                end
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] er, ey, eg, dm;
        dm = N'(1) << m_phase;
        er = '1;
        ey = '0;
        eg = '0;
        case (m_mode)
            M_GR: begin eg = dm; er = ~dm; end
            M_YE: begin ey = dm; er = ~dm; end
            M_FL: begin
                ey = {N{m_flash}} & N'(1);
                er = {N{m_flash}} & ~N'(1);
            end
            default: er = '1;
        endcase
        chk({tag, "_red"},    32'(red),    32'(er));
        chk({tag, "_yellow"}, 32'(yellow), 32'(ey));
        chk({tag, "_green"},  32'(green),  32'(eg));
        chk({tag, "_phase"},  32'(phase),  32'(m_phase));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic reset_dut(input logic [N-1:0] s);
        @(negedge clk);
        rst        = 1'b1;
        sensor     = s;
        night_mode = 1'b0;
        model_reset();
        @(negedge clk);
        check_model("reset");
        rst = 1'b0;
    endtask

    initial begin
        int  n_g, n_y, n_ar, n_other;
        bit  seen;

        // Idle: one all-red cycle then green 0 rests forever.
        reset_dut('0);
        for (int i = 0; i < 55; i++) tick("t036");
        chk("t036_green_rest", 32'(green), 32'h1);
        chk("t036_phase_rest", 32'(phase), 32'h0);

        // Demand only on direction 2 straight out of reset.
        reset_dut(4'b0100);
        tick("t037");
        chk("t037_first_green", 32'(green), 32'h4);
        for (int i = 0; i < 20; i++) tick("t037");
        chk("t037_green_rest", 32'(green), 32'h4);
        chk("t037_phase_rest", 32'(phase), 32'h2);

        // Own demand held: green runs to the maximum.
        reset_dut(4'b0001);
        n_g = 0; n_y = 0; n_ar = 0;
        for (int i = 0; i < 20; i++) begin
            tick("t038");
            if (i == 0) sensor = 4'b0011;
            if (green == 4'b0001) n_g++;
            else if (yellow == 4'b0001) n_y++;
            else if (red == 4'b1111) n_ar++;
        end
        chk("t038_green0_cycles", 32'(n_g), 32'd10);
        chk("t038_yellow0_cycles", 32'(n_y), 32'd2);
        chk("t038_allred_cycles", 32'(n_ar), 32'd1);
        chk("t038_next_green", 32'(green), 32'h2);

        // No own demand: green ends at the minimum.
        reset_dut('0);
        n_g = 0; n_y = 0; n_ar = 0; n_other = 0;
        for (int i = 0; i < 12; i++) begin
            tick("t039");
            if (i == 0) sensor = 4'b1000;
            if (green == 4'b0001) n_g++;
            else if (yellow == 4'b0001) n_y++;
            else if (red == 4'b1111) n_ar++;
            else if (green == 4'b1000) n_other++;
        end
        chk("t039_green0_cycles", 32'(n_g), 32'd4);
        chk("t039_yellow0_cycles", 32'(n_y), 32'd2);
        chk("t039_allred_cycles", 32'(n_ar), 32'd1);
        chk("t039_green3_cycles", 32'(n_other), 32'd5);
        chk("t039_phase", 32'(phase), 32'h3);

        // Night mode: clear through yellow and all-red into flashing.
        reset_dut('0);
        tick("t040");
        night_mode = 1'b1;
        for (int i = 0; i < 6; i++) tick("t040");
        for (int k = 0; k < 12; k++) begin
            tick("t040");
            chk("t040_flash_yellow", 32'(yellow), ((k / 3) % 2 == 0) ? 32'h1 : 32'h0);
            chk("t040_flash_red",    32'(red),    ((k / 3) % 2 == 0) ? 32'hE : 32'h0);
            chk("t040_flash_green",  32'(green),  32'h0);
        end
        night_mode = 1'b0;
        tick("t040");
        chk("t040_exit_allred", 32'(red), 32'hF);
        chk("t040_exit_phase", 32'(phase), 32'h3);
        tick("t040");
        chk("t040_resume_green", 32'(green), 32'h1);

        // Asynchronous reset in the middle of a yellow.
        reset_dut('0);
        tick("t041");
        sensor = 4'b0010;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick("t041");
            if (yellow == 4'b0001) seen = 1'b1;
        end
        chk("t041_yellow_seen", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("t041_async_red", 32'(red), 32'hF);
        chk("t041_async_yellow", 32'(yellow), 32'h0);
        chk("t041_async_green", 32'(green), 32'h0);
        chk("t041_async_phase", 32'(phase), 32'h3);
        sensor = '0;
        @(negedge clk);
        rst = 1'b0;
        tick("t041");
        chk("t041_first_green", 32'(green), 32'h1);
        for (int i = 0; i < 10; i++) tick("t041");
        chk("t041_green_rest", 32'(green), 32'h1);

        // Randomized demand and occasional night periods.
        reset_dut('0);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                sensor = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
            end
            if ($urandom_range(0, 59) == 0) night_mode = !night_mode;
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
